// File: rtl/convclk_pkg.sv
// ============================================================================
// convclk_pkg : shared types and elaboration helpers for the 1x->Nx converter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package convclk_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam int c_good_w = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit params_legal(input int width, input int chan,
                                        input int ratio, input int offset,
                                        input int lockcnt);
        return (width >= 1) && (chan >= 1) &&
               (ratio >= 2) && (ratio <= 16) &&
               (offset >= 0) && (offset < ratio) &&
               (lockcnt >= 1) && (lockcnt <= 15);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fflopxe.sv
// ============================================================================
// fflopxe : enabled flop bank with asynchronous active-low reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module fflopxe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = en ? d : q_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/phasedet_cknx.sv
// ============================================================================
// phasedet_cknx : recovers slow-clock phase from ph1x, tracks lock and
//                 generates the capture strobe plus locked/perr status
// Revision      : 1.0
// ============================================================================
`default_nettype none

module phasedet_cknx
    import convclk_pkg::*;
#(
    parameter int RATIO   = 2,
    parameter int OFFSET  = 1,
    parameter int LOCKCNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ph1x,
    input  logic scanmode,
    output logic cap,
    output logic locked,
    output logic perr
);

    localparam int CW = clog2(RATIO);
    localparam logic [CW-1:0]       c_last    = CW'(RATIO - 1);
    localparam logic [CW-1:0]       c_offset  = CW'(OFFSET);
    localparam logic [c_good_w-1:0] c_lockcnt = c_good_w'(LOCKCNT);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [c_good_w-1:0] good_q, good_d;
    logic                ph_r_q, locked_q, locked_d, perr_q, perr_d;

    logic                w_rise, w_cnt_zero, w_consistent, w_slip, w_missing, w_mismatch;
    logic [CW-1:0]       w_ph;
    logic [c_good_w-1:0] w_good_inc;

    // A rise always restarts the phase, so a rise and a missing edge never coincide.
    always_comb begin
        w_rise       = ph1x & ~ph_r_q;
        w_ph         = w_rise ? '0 : cnt_q;
        w_cnt_zero   = (cnt_q == '0);
        w_consistent = w_rise & w_cnt_zero;
        w_slip       = w_rise & ~w_cnt_zero;
        w_missing    = ~w_rise & w_cnt_zero;
        w_mismatch   = w_slip | w_missing;
        cnt_d        = (w_ph == c_last) ? '0 : w_ph + CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        perr_d     = 1'b0;
        w_good_inc = good_q + c_good_w'(1);
        case (state_q)
            HUNT: begin
                if (w_rise) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK: begin
                if (w_consistent) begin
                    good_d = w_good_inc;
                    if (w_good_inc == c_lockcnt) state_d = LOCK;
                end else if (w_slip) begin
                    good_d = '0;
                end else if (w_missing) begin
                    state_d = HUNT;
                    good_d  = '0;
                end
            end
            LOCK: begin
                if (w_mismatch) begin
                    perr_d  = 1'b1;
                    state_d = w_slip ? TRACK : HUNT;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = HUNT;
                good_d  = '0;
            end
        endcase
        locked_d = (state_d == LOCK);
    end

    // The mismatch cycle itself never captures, even when it lands on the capture phase.
    assign cap = ((state_q == LOCK) & ~w_mismatch & (w_ph == c_offset)) | scanmode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            good_q   <= '0;
            ph_r_q   <= 1'b0;
            locked_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            ph_r_q   <= ph1x;
            locked_q <= locked_d;
            perr_q   <= perr_d;
        end
    end

    assign locked = locked_q;
    assign perr   = perr_q;

endmodule

`default_nettype wire

// File: rtl/convclk1x_nx.sv
// ============================================================================
// convclk1x_nx : slow-to-fast boundary converter running in the fast domain;
//                captures CHAN slow-rate channels at a programmable phase
// Revision     : 1.0
// ============================================================================
`default_nettype none

module convclk1x_nx
    import convclk_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CHAN    = 2,
    parameter int RATIO   = 2,
    parameter int OFFSET  = 1,
    parameter int LOCKCNT = 4
) (
    input  logic                  clknx,
    input  logic                  rstnx_,
    input  logic                  scanmode,
    input  logic                  ph1x,
    input  logic [CHAN-1:0]       sync1x,
    input  logic [CHAN*WIDTH-1:0] data1x,
    output logic [CHAN-1:0]       syncnx,
    output logic [CHAN*WIDTH-1:0] datanx,
    output logic                  locked,
    output logic                  perr
);

    if (!params_legal(WIDTH, CHAN, RATIO, OFFSET, LOCKCNT)) begin : g_param_check
        $error("convclk1x_nx: illegal WIDTH/CHAN/RATIO/OFFSET/LOCKCNT combination");
    end

    logic            w_cap;
    logic [CHAN-1:0] syncnx_q, syncnx_d;

    phasedet_cknx #(
        .RATIO   (RATIO),
        .OFFSET  (OFFSET),
        .LOCKCNT (LOCKCNT)
    ) u_phasedet (
        .clk      (clknx),
        .rst_n    (rstnx_),
        .ph1x     (ph1x),
        .scanmode (scanmode),
        .cap      (w_cap),
        .locked   (locked),
        .perr     (perr)
    );

    for (genvar c = 0; c < CHAN; c++) begin : g_chan
        fflopxe #(
            .WIDTH (WIDTH)
        ) u_data_flop (
            .clk   (clknx),
            .rst_n (rstnx_),
            .en    (w_cap),
            .d     (data1x[c*WIDTH +: WIDTH]),
            .q     (datanx[c*WIDTH +: WIDTH])
        );
    end

    // Qualifiers are zeroed off-phase so each slow period yields at most one pulse.
    always_comb begin
        syncnx_d = w_cap ? sync1x : '0;
    end

    always_ff @(posedge clknx or negedge rstnx_) begin
        if (!rstnx_) syncnx_q <= '0;
        else         syncnx_q <= syncnx_d;
    end

    assign syncnx = syncnx_q;

endmodule

`default_nettype wire
